// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
// Shares one single-port SRAM between the instruction-fetch port and the
// data-bus RAM port. At most one access is issued per cycle; the one-cycle
// read response is routed back to the port that was granted. Addresses
// outside [AddrBase, AddrBase+MemSize) are granted but never reach the SRAM;
// they get an error response instead.
//
// Optional feature macro: RAM_ARB_FAIR_EN
//   defined   : a 4-bit starvation counter gives data priority once it has
//               been blocked MaxWait cycles in a row.
//   undefined : strict instruction priority, no counter.
//
// Ports
//   clk_sys, rst_sys_n          clock, async active-low reset
//   instr_req/addr_i            fetch request
//   instr_gnt/rvalid/rdata/err  fetch grant (comb) and response (1 cycle later)
//   data_req/we/be/addr/wdata_i data request
//   data_gnt/rvalid/rdata/err   data grant (comb) and response (1 cycle later)
//   mem_req/we/be/addr/wdata_o  SRAM request, driven in the grant cycle
//   mem_rdata_i                 SRAM read data, valid the cycle after mem_req_o
`timescale 1ns/1ps

module ram_port_arbiter #(
  parameter logic [31:0] AddrBase = 32'h0010_0000,
  parameter int unsigned MemSize  = 1048576,
  parameter int unsigned MaxWait  = 4
) (
  input  logic        clk_sys,
  input  logic        rst_sys_n,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i
);

  localparam logic [31:0] MEM_SIZE_W = 32'(MemSize);

  // Reject illegal starvation limits at elaboration time.
  if ((MaxWait < 32'd1) || (MaxWait > 32'd15)) begin : g_bad_max_wait
    $fatal(1, "ram_port_arbiter: MaxWait must be in 1..15");
  end

  logic w_instr_in_range;
  logic w_data_in_range;
  logic w_instr_gnt;
  logic w_data_gnt;
  logic r_rsp_instr;
  logic r_rsp_data;
  logic r_rsp_err;

  // Unsigned wrap makes addresses below AddrBase look huge, so they fail too.
  assign w_instr_in_range = (instr_addr_i - AddrBase) < MEM_SIZE_W;
  assign w_data_in_range  = (data_addr_i  - AddrBase) < MEM_SIZE_W;

`ifdef RAM_ARB_FAIR_EN
  localparam logic [3:0] MAX_WAIT_W = 4'(MaxWait);

  logic [3:0] r_wait_cnt;
  logic       w_starved;

  assign w_starved  = (r_wait_cnt == MAX_WAIT_W);
  // Grants are forced low during reset so nothing reaches the SRAM.
  assign w_data_gnt = rst_sys_n & data_req_i & (~instr_req_i | w_starved);

  // Count consecutive blocked data cycles, saturating at MaxWait.
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      r_wait_cnt <= 4'd0;
    end else if (data_req_i && !w_data_gnt) begin
      r_wait_cnt <= w_starved ? r_wait_cnt : (r_wait_cnt + 4'd1);
    end else begin
      r_wait_cnt <= 4'd0;
    end
  end
`else
  assign w_data_gnt = rst_sys_n & data_req_i & ~instr_req_i;
`endif

  assign w_instr_gnt = rst_sys_n & instr_req_i & ~w_data_gnt;
  assign instr_gnt_o = w_instr_gnt;
  assign data_gnt_o  = w_data_gnt;

  // SRAM request mux: only in-range grants are forwarded, everything else is 0.
  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_be_o    = 4'h0;
    mem_addr_o  = 32'h0;
    mem_wdata_o = 32'h0;
    if (w_instr_gnt && w_instr_in_range) begin
      mem_req_o   = 1'b1;
      mem_we_o    = 1'b0;
      mem_be_o    = 4'hF;
      mem_addr_o  = instr_addr_i;
      mem_wdata_o = 32'h0;
    end else if (w_data_gnt && w_data_in_range) begin
      mem_req_o   = 1'b1;
      mem_we_o    = data_we_i;
      mem_be_o    = data_be_i;
      mem_addr_o  = data_addr_i;
      mem_wdata_o = data_wdata_i;
    end else begin
      mem_req_o   = 1'b0;
    end
  end

  // Remember who was granted and whether it was an out-of-range access.
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      r_rsp_instr <= 1'b0;
      r_rsp_data  <= 1'b0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_instr <= w_instr_gnt;
      r_rsp_data  <= w_data_gnt;
      r_rsp_err   <= (w_instr_gnt & ~w_instr_in_range) |
                     (w_data_gnt  & ~w_data_in_range);
    end
  end

  assign instr_rvalid_o = r_rsp_instr;
  assign instr_err_o    = r_rsp_instr & r_rsp_err;
  assign instr_rdata_o  = (r_rsp_instr & ~r_rsp_err) ? mem_rdata_i : 32'h0;
  assign data_rvalid_o  = r_rsp_data;
  assign data_err_o     = r_rsp_data & r_rsp_err;
  assign data_rdata_o   = (r_rsp_data & ~r_rsp_err) ? mem_rdata_i : 32'h0;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed testbench for ram_port_arbiter with a behavioural one-cycle SRAM
// and a response scoreboard: each checked grant cycle pushes the response the
// following cycle must show; the response check pops and compares it.
`timescale 1ns/1ps

module tb_ram_port_arbiter;

  logic        clk_sys = 1'b0;
  logic        rst_sys_n;
  logic        instr_req_i;
  logic [31:0] instr_addr_i;
  logic        instr_gnt_o;
  logic        instr_rvalid_o;
  logic [31:0] instr_rdata_o;
  logic        instr_err_o;
  logic        data_req_i;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i;
  logic [31:0] data_wdata_i;
  logic        data_gnt_o;
  logic        data_rvalid_o;
  logic [31:0] data_rdata_o;
  logic        data_err_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic        iv;
    logic        dv;
    logic        err;
    logic        chk_rd;
    logic [31:0] rd;
  } rsp_t;
  rsp_t exp_q[$];

  logic [31:0] sram [0:1023];

  ram_port_arbiter dut (
    .clk_sys(clk_sys), .rst_sys_n(rst_sys_n),
    .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i),
    .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o),
    .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
    .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
    .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
    .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
    .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );

  always #10 clk_sys = ~clk_sys;

  // Behavioural single-port SRAM, one-cycle read latency.
  always @(posedge clk_sys) begin
    if (mem_req_o) begin
      if (mem_we_o) begin
        for (int b = 0; b < 4; b++)
          if (mem_be_o[b]) sram[mem_addr_o[11:2]][8*b +: 8] <= mem_wdata_o[8*b +: 8];
      end else begin
        mem_rdata_i <= sram[mem_addr_o[11:2]];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_i(input logic req, input logic [31:0] addr);
    instr_req_i  = req;
    instr_addr_i = addr;
  endtask

  task automatic set_d(input logic req, input logic we, input logic [3:0] be,
                       input logic [31:0] addr, input logic [31:0] wdata);
    data_req_i   = req;
    data_we_i    = we;
    data_be_i    = be;
    data_addr_i  = addr;
    data_wdata_i = wdata;
  endtask

  // Called just after a rising edge: checks grants mid-cycle, queues the response.
  task automatic check_grant(input logic e_ig, input logic e_dg, input logic e_mreq,
                             input logic e_err, input logic e_chk, input logic [31:0] e_rd);
    rsp_t r;
    #2;
    chk("instr_gnt", 32'(instr_gnt_o), 32'(e_ig));
    chk("data_gnt",  32'(data_gnt_o),  32'(e_dg));
    chk("mem_req",   32'(mem_req_o),   32'(e_mreq));
    r.iv = e_ig; r.dv = e_dg; r.err = e_err; r.chk_rd = e_chk; r.rd = e_rd;
    exp_q.push_back(r);
  endtask

  // Advances past the next rising edge and compares the response outputs.
  task automatic check_rsp();
    rsp_t r;
    @(posedge clk_sys);
    #1;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $error("FAIL scoreboard: observed empty queue expected entry");
    end else begin
      r = exp_q.pop_front();
      chk("instr_rvalid", 32'(instr_rvalid_o), 32'(r.iv));
      chk("data_rvalid",  32'(data_rvalid_o),  32'(r.dv));
      chk("instr_err",    32'(instr_err_o),    32'(r.iv & r.err));
      chk("data_err",     32'(data_err_o),     32'(r.dv & r.err));
      if (!r.iv)              chk("instr_rdata_idle", instr_rdata_o, 32'h0);
      else if (r.chk_rd)      chk("instr_rdata", instr_rdata_o, r.rd);
      if (!r.dv)              chk("data_rdata_idle", data_rdata_o, 32'h0);
      else if (r.chk_rd)      chk("data_rdata", data_rdata_o, r.rd);
    end
  endtask

  initial begin
    logic dg;
    for (int i = 0; i < 1024; i++) sram[i] = 32'h0;
    sram[10'h020] = 32'h0000_0013;
    sram[10'h3FF] = 32'hA5A5_5A5A;
    mem_rdata_i = 32'h1234_5678;
    rst_sys_n = 1'b0;
    set_i(1'b1, 32'h0010_0080);
    set_d(1'b1, 1'b0, 4'hF, 32'h0010_0400, 32'h0);

    // Reset: requests present but nothing granted, all outputs low.
    #3;
    chk("rst_instr_gnt", 32'(instr_gnt_o), 32'h0);
    chk("rst_data_gnt",  32'(data_gnt_o),  32'h0);
    chk("rst_mem_req",   32'(mem_req_o),   32'h0);
    chk("rst_mem_addr",  mem_addr_o,       32'h0);
    @(posedge clk_sys); #1;
    chk("rst_instr_rvalid", 32'(instr_rvalid_o), 32'h0);
    chk("rst_data_rvalid",  32'(data_rvalid_o),  32'h0);
    chk("rst_instr_rdata",  instr_rdata_o,       32'h0);
    set_i(1'b0, 32'h0);
    set_d(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    rst_sys_n = 1'b1;
    check_grant(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0); check_rsp();

    // Single fetch.
    set_i(1'b1, 32'h0010_0080);
    check_grant(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0013);
    chk("fetch_mem_we",   32'(mem_we_o), 32'h0);
    chk("fetch_mem_be",   32'(mem_be_o), 32'hF);
    chk("fetch_mem_addr", mem_addr_o,    32'h0010_0080);
    check_rsp();

    // Data write then read back, back to back.
    set_i(1'b0, 32'h0);
    set_d(1'b1, 1'b1, 4'hF, 32'h0010_0400, 32'hDEAD_BEEF);
    check_grant(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("wr_mem_we",    32'(mem_we_o), 32'h1);
    chk("wr_mem_be",    32'(mem_be_o), 32'hF);
    chk("wr_mem_wdata", mem_wdata_o,   32'hDEAD_BEEF);
    check_rsp();
    set_d(1'b1, 1'b0, 4'hF, 32'h0010_0400, 32'h0);
    check_grant(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF); check_rsp();

    // Range boundaries: below base, last word, one past the end.
    set_d(1'b1, 1'b0, 4'hF, 32'h0002_0000, 32'h0);
    check_grant(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0); check_rsp();
    set_d(1'b1, 1'b0, 4'hF, 32'h0020_0000, 32'h0);
    check_grant(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0); check_rsp();
    set_d(1'b1, 1'b0, 4'hF, 32'h001F_FFFC, 32'h0);
    check_grant(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'hA5A5_5A5A); check_rsp();
    set_d(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    set_i(1'b1, 32'h000F_FFFC);
    check_grant(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0); check_rsp();

    // Contention: both ports request continuously.
    set_i(1'b1, 32'h0010_0080);
    set_d(1'b1, 1'b0, 4'hF, 32'h0010_0400, 32'h0);
    for (int k = 0; k < 10; k++) begin
`ifdef RAM_ARB_FAIR_EN
      dg = ((k % 5) == 4);
`else
      dg = 1'b0;
`endif
      check_grant(~dg, dg, 1'b1, 1'b0, 1'b1, dg ? 32'hDEAD_BEEF : 32'h0000_0013);
      check_rsp();
    end
    set_i(1'b0, 32'h0);
    check_grant(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF); check_rsp();

    // Data drops its request mid-wait: the starvation count restarts.
    set_i(1'b1, 32'h0010_0080);
    for (int k = 0; k < 2; k++) begin
      check_grant(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0013); check_rsp();
    end
    set_d(1'b0, 1'b0, 4'hF, 32'h0010_0400, 32'h0);
    check_grant(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0013); check_rsp();
    set_d(1'b1, 1'b0, 4'hF, 32'h0010_0400, 32'h0);
    for (int k = 0; k < 5; k++) begin
`ifdef RAM_ARB_FAIR_EN
      dg = (k == 4);
`else
      dg = 1'b0;
`endif
      check_grant(~dg, dg, 1'b1, 1'b0, 1'b1, dg ? 32'hDEAD_BEEF : 32'h0000_0013);
      check_rsp();
    end
    set_d(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    set_i(1'b0, 32'h0);
    check_grant(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0); check_rsp();

    // Reset mid-access: granted fetch is discarded.
    set_i(1'b1, 32'h0010_0080);
    check_grant(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0013);
    #2;
    rst_sys_n = 1'b0;
    #2;
    chk("midrst_instr_gnt", 32'(instr_gnt_o), 32'h0);
    chk("midrst_mem_req",   32'(mem_req_o),   32'h0);
    @(posedge clk_sys); #1;
    chk("midrst_instr_rvalid", 32'(instr_rvalid_o), 32'h0);
    chk("midrst_instr_rdata",  instr_rdata_o,       32'h0);
    exp_q.delete();
    set_i(1'b0, 32'h0);
    rst_sys_n = 1'b1;
    check_grant(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0); check_rsp();
    set_i(1'b1, 32'h0010_0080);
    check_grant(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0013); check_rsp();
    set_i(1'b0, 32'h0);
    check_grant(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0); check_rsp();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
